seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered ALU for the MIPS datapath with a start/done handshake.
- Single-cycle ops: logic, add/sub, shift, compare. Multi-cycle ops: unsigned shift-add multiply and restoring divide, producing a double-width result on dataC/dataHi.
- Flags are registered alongside the result. Sits between the register file read stage and writeback/HI-LO registers; the control FSM stalls on busy.

Parameters:
- WORD_LENGTH, 32: operand/result width; even, >=8.
- SHAMT_W, $clog2(WORD_LENGTH): shift-amount width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  op request; sampled only when not busy.
- control  in  4  opcode.
- dataA  in  WORD_LENGTH  operand A.
- dataB  in  WORD_LENGTH  operand B.
- shmt  in  SHAMT_W  immediate shift amount.
- busy  out  1  multi-cycle op in progress.
- done  out  1  one-cycle pulse: results valid.
- dataC  out  WORD_LENGTH  result; MULU low word; DIVU quotient.
- dataHi  out  WORD_LENGTH  MULU high word; DIVU remainder; 0 otherwise.
- carry  out  1  ADD carry-out; SUB no-borrow (A>=B unsigned); MULU high word !=0; else 0.
- overflow  out  1  signed overflow for ADD/SUB; else 0.
- zero  out  1  dataC==0.
- negative  out  1  dataC[WORD_LENGTH-1].
- div_by_zero  out  1  DIVU with dataB==0.

Behaviour:
- Reset (async): state=IDLE; all outputs 0, including counter and internal shift registers.
- Opcodes:
  - 0000 MULU (multi-cycle)
  - 0001 SUB A-B
  - 0010 ADD
  - 0011 NOT A
  - 0100 NEG (two's complement A)
  - 0101 AND
  - 0110 OR
  - 0111 XOR
  - 1000 SLL B<<shmt
  - 1001 SRL B>>shmt
  - 1010 SLLV B<<A[SHAMT_W-1:0]
  - 1011 LUI B<<(WORD_LENGTH/2)
  - 1100 SLTU (unsigned A<B -> 1)
  - 1101 SRA B>>>shmt
  - 1110 DIVU (multi-cycle)
  - 1111 SLT (signed A<B -> 1)
- FSM states IDLE, RUN, DONE:
  - IDLE or DONE, start=1, single-cycle op -> DONE. Result registered at that edge; done=1 the following cycle (latency 1).
  - IDLE or DONE, start=1, MULU/DIVU -> RUN. Operands latched, cycle counter loaded with WORD_LENGTH-1, busy=1.
  - RUN: one multiply/divide step per cycle. At count 0 -> DONE with results registered. done rises WORD_LENGTH+1 cycles after the start edge; busy falls the same edge.
  - DONE, start=0 -> IDLE. done lasts exactly one cycle.
  - Back-to-back: start in DONE is accepted, so done can stay high on consecutive cycles.
- start during RUN is ignored; no queueing. control/dataA/dataB may change during RUN without effect.
- Outputs hold their last values in IDLE/RUN until the next result is registered.
- MULU: unsigned; {dataHi,dataC} = A*B (2*WORD_LENGTH bits).
- DIVU, B!=0: dataC=A/B, dataHi=A%B.
- DIVU, B==0: dataC=all ones, dataHi=A, div_by_zero=1. Full WORD_LENGTH+1 latency still applies.
- div_by_zero is cleared on the next registered result.
- Shifts use only the low SHAMT_W bits of the amount; SRA sign-fills.
- reset asserted during RUN aborts immediately: done is never pulsed for that op.

Test Plan:
- Reset idle: reset pulse -> all outputs 0, busy=0. start ADD A=0xFFFFFFFF, B=1 -> next cycle done=1, dataC=0, carry=1, zero=1, overflow=0.
- ADD overflow: A=0x7FFFFFFF, B=1 -> dataC=0x80000000, overflow=1, negative=1, carry=0.
- SUB, then SLT/SLTU: A=3, B=5 -> dataC=0xFFFFFFFE, carry=0, negative=1. SLT A=0xFFFFFFFF, B=1 -> 1. SLTU same operands -> 0.
- MULU: A=0xFFFFFFFF, B=2 -> busy for 32 cycles, done at cycle 33, dataC=0xFFFFFFFE, dataHi=1, carry=1. start pulsed mid-RUN is ignored.
- DIVU: A=100, B=7 -> done at cycle 33, dataC=14, dataHi=2. Then B=0 -> dataC=0xFFFFFFFF, dataHi=100, div_by_zero=1. The next ADD clears div_by_zero.
- Reset mid-op and back-to-back: reset at RUN cycle 10 -> outputs 0, no done pulse. SRA shmt=4, B=0x80000000 -> 0xF8000000. start held high into DONE with an XOR op -> done high on two consecutive cycles.

Source files
------------

// File: rtl/seq_alu.sv
// Registered ALU with a start/done handshake: single-cycle logic/arith/shift/compare
// ops plus multi-cycle unsigned shift-add multiply and restoring divide.
module seq_alu #(
  parameter int WORD_LENGTH = 32,
  parameter int SHAMT_W     = $clog2(WORD_LENGTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             control,
  input  logic [WORD_LENGTH-1:0] dataA,
  input  logic [WORD_LENGTH-1:0] dataB,
  input  logic [SHAMT_W-1:0]     shmt,
  output logic                   busy,
  output logic                   done,
  output logic [WORD_LENGTH-1:0] dataC,
  output logic [WORD_LENGTH-1:0] dataHi,
  output logic                   carry,
  output logic                   overflow,
  output logic                   zero,
  output logic                   negative,
  output logic                   div_by_zero
);

  localparam int W     = WORD_LENGTH;
  localparam int CNT_W = $clog2(WORD_LENGTH);

  typedef enum logic [3:0] {
    OP_MULU, OP_SUB, OP_ADD, OP_NOT, OP_NEG, OP_AND, OP_OR, OP_XOR,
    OP_SLL, OP_SRL, OP_SLLV, OP_LUI, OP_SLTU, OP_SRA, OP_DIVU, OP_SLT
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state;
  logic [CNT_W-1:0] count;
  logic [W-1:0]     acc_hi;   // multiply: partial product high word; divide: remainder
  logic [W-1:0]     acc_lo;   // multiply: multiplier / product low word; divide: quotient
  logic [W-1:0]     opnd;     // multiplicand or divisor
  logic             is_div;

  op_e  op;
  logic is_multi;
  assign op       = op_e'(control);
  assign is_multi = (op == OP_MULU) || (op == OP_DIVU);

  // Single-cycle datapath
  logic [W:0]   add_full, sub_full;
  logic [W-1:0] alu_res;
  logic         alu_carry, alu_ovf;

  assign add_full = {1'b0, dataA} + {1'b0, dataB};
  assign sub_full = {1'b0, dataA} - {1'b0, dataB};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op)
      OP_SUB: begin
        alu_res   = sub_full[W-1:0];
        alu_carry = ~sub_full[W];
        alu_ovf   = (dataA[W-1] != dataB[W-1]) && (sub_full[W-1] != dataA[W-1]);
      end
      OP_ADD: begin
        alu_res   = add_full[W-1:0];
        alu_carry = add_full[W];
        alu_ovf   = (dataA[W-1] == dataB[W-1]) && (add_full[W-1] != dataA[W-1]);
      end
      OP_NOT:  alu_res = ~dataA;
      OP_NEG:  alu_res = '0 - dataA;
      OP_AND:  alu_res = dataA & dataB;
      OP_OR:   alu_res = dataA | dataB;
      OP_XOR:  alu_res = dataA ^ dataB;
      OP_SLL:  alu_res = dataB << shmt;
      OP_SRL:  alu_res = dataB >> shmt;
      OP_SLLV: alu_res = dataB << dataA[SHAMT_W-1:0];
      OP_LUI:  alu_res = dataB << (W / 2);
      OP_SLTU: alu_res = {{(W-1){1'b0}}, (dataA < dataB)};
      OP_SRA:  alu_res = W'($signed(dataB) >>> shmt);
      OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
      default: alu_res = '0;
    endcase
  end

  // One multiply or divide step per cycle
  logic [W:0]   mul_sum;
  logic [W:0]   div_shift;
  logic         div_ge;
  logic [W-1:0] div_sub;
  logic [W-1:0] next_hi, next_lo;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[W-1]};
    div_ge    = div_shift >= {1'b0, opnd};
    // The restored remainder is always below the divisor, so W bits suffice.
    div_sub   = div_shift[W-1:0] - opnd;
    if (is_div) begin
      next_hi = div_ge ? div_sub : div_shift[W-1:0];
      next_lo = {acc_lo[W-2:0], div_ge};
    end else begin
      next_hi = mul_sum[W:1];
      next_lo = {mul_sum[0], acc_lo[W-1:1]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset clears every register,
  // including the step accumulators, so an aborted op leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      count       <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd        <= '0;
      is_div      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      dataC       <= '0;
      dataHi      <= '0;
      carry       <= 1'b0;
      overflow    <= 1'b0;
      zero        <= 1'b0;
      negative    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (!start) begin
            state <= S_IDLE;
          end else if (is_multi) begin
            state  <= S_RUN;
            busy   <= 1'b1;
            count  <= CNT_W'(W - 1);
            is_div <= (op == OP_DIVU);
            acc_hi <= '0;
            acc_lo <= (op == OP_DIVU) ? dataA : dataB;
            opnd   <= (op == OP_DIVU) ? dataB : dataA;
          end else begin
            state       <= S_DONE;
            done        <= 1'b1;
            dataC       <= alu_res;
            dataHi      <= '0;
            carry       <= alu_carry;
            overflow    <= alu_ovf;
            zero        <= (alu_res == '0);
            negative    <= alu_res[W-1];
            div_by_zero <= 1'b0;
          end
        end
        S_RUN: begin
          acc_hi <= next_hi;
          acc_lo <= next_lo;
          count  <= count - CNT_W'(1);
          if (count == '0) begin
            state       <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            dataC       <= next_lo;
            dataHi      <= next_hi;
            carry       <= !is_div && (next_hi != '0);
            overflow    <= 1'b0;
            zero        <= (next_lo == '0);
            negative    <= next_lo[W-1];
            div_by_zero <= is_div && (opnd == '0);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases plus randomized ops scored
// against an arithmetic reference model.
module tb_seq_alu;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [3:0]    control;
  logic [W-1:0]  dataA, dataB;
  logic [4:0]    shmt;
  logic          busy, done;
  logic [W-1:0]  dataC, dataHi;
  logic          carry, overflow, zero, negative, div_by_zero;

  int errors = 0;
  int checks = 0;

  seq_alu #(.WORD_LENGTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .control(control),
    .dataA(dataA), .dataB(dataB), .shmt(shmt),
    .busy(busy), .done(done), .dataC(dataC), .dataHi(dataHi),
    .carry(carry), .overflow(overflow), .zero(zero), .negative(negative),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: results straight from the opcode definitions.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [4:0] sh, output logic [W-1:0] c, output logic [W-1:0] hi,
                                output logic cy, output logic ov, output logic dz);
    longint       s;
    logic [63:0]  p;
    c = '0; hi = '0; cy = 1'b0; ov = 1'b0; dz = 1'b0;
    case (op)
      4'd0: begin
        p  = {32'b0, a} * {32'b0, b};
        c  = p[31:0];
        hi = p[63:32];
        cy = (hi != 0);
      end
      4'd1: begin
        c  = a - b;
        cy = (a >= b);
        s  = longint'($signed(a)) - longint'($signed(b));
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2: begin
        s  = longint'(a) + longint'(b);
        c  = s[31:0];
        cy = (s > 64'sd4294967295);
        s  = longint'($signed(a)) + longint'($signed(b));
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd3:  c = ~a;
      4'd4:  c = 0 - a;
      4'd5:  c = a & b;
      4'd6:  c = a | b;
      4'd7:  c = a ^ b;
      4'd8:  c = b << sh;
      4'd9:  c = b >> sh;
      4'd10: c = b << a[4:0];
      4'd11: c = b << 16;
      4'd12: c = (a < b) ? 1 : 0;
      4'd13: c = $signed(b) >>> sh;
      4'd14: begin
        if (b == 0) begin
          c = '1; hi = a; dz = 1'b1;
        end else begin
          c = a / b; hi = a % b;
        end
      end
      default: c = ($signed(a) < $signed(b)) ? 1 : 0;
    endcase
  endfunction

  // Issue one op, wait for done (bounded), check latency, busy and every result output.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [4:0] sh, input bit poke);
    logic [W-1:0] ec, ehi;
    logic ecy, eov, edz;
    bit multi;
    int cycles, busy_bad;
    model(op, a, b, sh, ec, ehi, ecy, eov, edz);
    multi = (op == 4'd0) || (op == 4'd14);
    @(negedge clk);
    control = op; dataA = a; dataB = b; shmt = sh; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    busy_bad = 0;
    while (!done && cycles < 100) begin
      if (!busy) busy_bad++;
      control = 4'($urandom); dataA = $urandom; dataB = $urandom; shmt = 5'($urandom);
      start = (poke && cycles == 5);
      @(negedge clk);
      start = 1'b0;
      cycles++;
    end
    check({tag, "_latency"}, cycles, multi ? W + 1 : 1);
    check({tag, "_busy_run"}, busy_bad, 0);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_dataC"}, dataC, ec);
    check({tag, "_dataHi"}, dataHi, ehi);
    check({tag, "_flags"}, {carry, overflow, zero, negative, div_by_zero},
          {ecy, eov, (ec == 0), ec[W-1], edz});
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen_done;
    reset = 1'b1; start = 1'b0; control = '0; dataA = '0; dataB = '0; shmt = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done, dataC, dataHi, carry, overflow, zero, negative, div_by_zero}, '0);
    reset = 1'b0;

    run_op("add_wrap", 4'd2, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
    check("add_wrap_lit", {dataC, 3'(carry), 3'(zero)}, {32'd0, 3'd1, 3'd1});
    run_op("add_ovf", 4'd2, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b0);
    run_op("sub", 4'd1, 32'd3, 32'd5, 5'd0, 1'b0);
    run_op("slt", 4'd15, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
    run_op("sltu", 4'd12, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
    run_op("mulu", 4'd0, 32'hFFFF_FFFF, 32'd2, 5'd0, 1'b1);
    check("mulu_lit", {dataHi, dataC}, 64'h1_FFFF_FFFE);
    run_op("divu", 4'd14, 32'd100, 32'd7, 5'd0, 1'b0);
    check("divu_lit", {dataHi, dataC}, {32'd2, 32'd14});
    run_op("divu_zero", 4'd14, 32'd100, 32'd0, 5'd0, 1'b0);
    run_op("add_clr_dz", 4'd2, 32'd1, 32'd2, 5'd0, 1'b0);
    run_op("sra", 4'd13, 32'd0, 32'h8000_0000, 5'd4, 1'b0);
    check("sra_lit", dataC, 32'hF800_0000);

    // Reset at RUN cycle 10 aborts the multiply; no done pulse may follow.
    @(negedge clk);
    control = 4'd0; dataA = 32'd12345; dataB = 32'd678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_outputs", {busy, done, dataC, dataHi, carry, overflow, zero, negative, div_by_zero}, '0);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("abort_no_done", seen_done, 0);

    // Back-to-back: start held through DONE with a second op.
    @(negedge clk);
    control = 4'd2; dataA = 32'd10; dataB = 32'd20; start = 1'b1;
    @(negedge clk);
    check("b2b_first", {31'd0, done, dataC}, {31'd0, 1'b1, 32'd30});
    control = 4'd7; dataA = 32'hF0F0_1234; dataB = 32'h0FF0_00FF;
    @(negedge clk);
    start = 1'b0;
    check("b2b_second", {31'd0, done, dataC}, {31'd0, 1'b1, 32'hFF00_12CB});
    @(negedge clk);
    check("b2b_end", done, 0);

    for (int i = 0; i < 150; i++)
      run_op($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)), pick(), pick(), 5'($urandom), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
